// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO read-side streaming blocks.
`timescale 1ns/1ps
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int DEF_D_SIZE    = 8;
  localparam int DEF_BURST_LEN = 4;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Downstream valid/ready stream carrying words popped from the FIFO.
`timescale 1ns/1ps
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int D_SIZE = DEF_D_SIZE
);

  logic              out_valid;
  logic              out_ready;
  logic [D_SIZE-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer; entry 0 is always the oldest word.
`timescale 1ns/1ps
module skid_buf2 #(
  parameter int WIDTH = 9
) (
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (occ != 2'd0);
  assign push_ok = push && ((occ != 2'd2) || pop_ok);
  assign head    = ent0;

  // NOTE: the entries are reset too, so the head reads as zero while reset is held.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (occ == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy stays put; the new word lands behind whatever remains.
          if (occ == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops fixed-length bursts from a first-word-fall-through FIFO into a valid/ready stream.
`timescale 1ns/1ps
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int D_SIZE    = DEF_D_SIZE,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              en,
  input  logic              r_empty,
  input  logic [D_SIZE-1:0] r_data,
  output logic              r_inc,
  output logic [15:0]       rd_count,
  fifo_rd_stream_if.master  out_if
);

  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  rd_state_e     state;
  logic [7:0]    idx;
  logic [1:0]    occ;
  logic [D_SIZE:0] head;
  logic          xfer;
  logic          drain_done;

  // Pop only while there is room; at occupancy 2 we wait even if downstream is ready.
  assign r_inc      = (state == BURST) && !r_empty && (occ < 2'd2);
  assign xfer       = out_if.out_valid && out_if.out_ready;
  assign drain_done = (occ == 2'd0) || ((occ == 2'd1) && xfer);

  skid_buf2 #(
    .WIDTH(D_SIZE + 1)
  ) u_buf (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .push      (r_inc),
    .push_data ({r_data, idx == LAST_IDX}),
    .pop       (xfer),
    .head      (head),
    .occ       (occ)
  );

  assign out_if.out_valid = (occ != 2'd0);
  assign out_if.out_data  = head[D_SIZE:1];
  assign out_if.out_last  = out_if.out_valid && head[0];

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      state <= IDLE;
      idx   <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state <= BURST;
            idx   <= 8'd0;
          end
        end
        BURST: begin
          if (r_inc) begin
            idx <= idx + 8'd1;
            if (idx == LAST_IDX) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      rd_count <= 16'd0;
    end else if (xfer && (rd_count != 16'hFFFF)) begin
      rd_count <= rd_count + 16'd1;
    end
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter D_SIZE, default 8, data word width; matches FIFO r_data width.
REQ-002 Parameter BURST_LEN, default 4, words popped per burst; legal range 1..255.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, exactly as listed in REQ-004 and REQ-005.
REQ-004 r_clk  input  1  read-domain clock; all state updates on rising edge.
REQ-005 r_rst  input  1  asynchronous, active-high reset (note: opposite polarity to FIFO-side r_rst; top level inverts).
REQ-006 en  input  1  burst enable, sampled only in IDLE.
REQ-007 r_empty  input  1  FIFO empty flag; r_data is valid combinationally whenever r_empty=0.
REQ-008 r_data  input  D_SIZE  FIFO head word (first-word fall-through).
REQ-009 r_inc  output  1  FIFO pop request, combinational.
REQ-010 out_valid  output  1  downstream word available.
REQ-011 out_ready  input  1  downstream accepts the word.
REQ-012 out_data  output  D_SIZE  downstream word.
REQ-013 out_last  output  1  marks the final word of a burst; qualified by out_valid.
REQ-014 rd_count  output  16  words delivered downstream, saturating.

Function
REQ-015 FSM states SHALL be IDLE, BURST, DRAIN.
REQ-016 IDLE->BURST SHALL occur when en=1; the burst index is cleared to 0 on entry.
REQ-017 In BURST, r_inc SHALL be 1 exactly when r_empty=0 and buffer occupancy <2; in IDLE and DRAIN, r_inc SHALL be 0.
REQ-018 Each pop SHALL write {r_data, index==BURST_LEN-1} into the 2-entry buffer on the same edge and increment the index.
REQ-019 The pop with index BURST_LEN-1 SHALL move the FSM to DRAIN; en is ignored until the next IDLE, so deasserting en mid-burst does not shorten the burst.
REQ-020 DRAIN->IDLE SHALL occur on the edge where the buffer becomes empty.
REQ-021 out_valid SHALL be 1 when occupancy >0; out_data and out_last SHALL come from the oldest entry.
REQ-022 A transfer occurs when out_valid && out_ready; out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous push and transfer SHALL leave occupancy unchanged and preserve FIFO order.
REQ-024 Latency: a pop on edge N SHALL make the word visible on out_data after edge N, if the buffer was empty.
REQ-025 At occupancy 2, r_inc SHALL be 0 even when out_ready=1; throughput is 1 word/cycle at occupancy <=1.
REQ-026 rd_count SHALL increment by 1 per transfer and hold at 16'hFFFF, with no wrap.
REQ-027 r_empty=1 during BURST SHALL stall the index with no pop; the burst resumes when data arrives.

Reset
REQ-028 While r_rst=1, the block SHALL hold: state=IDLE, occupancy=0, index=0, rd_count=0, out_valid=0, out_last=0, out_data=0, r_inc=0.
REQ-029 Reset asserted mid-burst SHALL discard buffered words immediately; no partial burst completes after release.
REQ-030 The first pop after reset release SHALL require en=1 in IDLE.

Structure
REQ-031 Shared package fifo_pkg SHALL hold the state enum (IDLE/BURST/DRAIN) and the default D_SIZE and BURST_LEN constants.
REQ-032 The 2-entry buffer SHALL be sub-module skid_buf2 (D_SIZE+1 wide, push/pop/occupancy); the FSM and counters live in fifo_rd_stream.

Verification
REQ-033 Drive en=1, out_ready=1, BURST_LEN=4, FIFO preloaded 0x11..0x14 -> four consecutive out words 0x11..0x14, out_last only on 0x14, FSM returns to IDLE, rd_count=4.
REQ-034 Hold out_ready=0 with 4 words available -> exactly 2 pops, r_inc=0 afterwards, out_data stable at first word; releasing out_ready delivers the rest in order.
REQ-035 FIFO has 2 words, burst starts -> 2 words delivered, r_inc held 0 while r_empty=1; push 2 more -> burst completes, out_last on 4th word.
REQ-036 Drop en after the 1st pop -> all 4 burst words still delivered; no new burst begins while en=0.
REQ-037 Assert r_rst with 2 words buffered -> out_valid=0, rd_count=0, r_inc=0 in the same cycle; after release, with en=0, no pops occur.
REQ-038 Force rd_count to 16'hFFFE and perform 3 transfers -> rd_count reads 16'hFFFF and holds.
